// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller: light indices, FSM
// state encodings and the duration clamp used by the timing controller.
package traffic_pkg;

    localparam int LIGHT_STATE_WIDTH = 3;

    localparam int GREEN_IDX  = 0;
    localparam int YELLOW_IDX = 1;
    localparam int RED_IDX    = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_RED    = 2'd3
    } light_state_e;

    // A zero-second phase would never produce a handover, so it becomes one second.
    function automatic logic [31:0] clamp_duration(input logic [31:0] dur);
        return (dur == 32'd0) ? 32'd1 : dur;
    endfunction

endpackage

// File: rtl/traffic_sec_prescaler.sv
// One-second timebase: counts clock cycles while enabled and flags the last
// two cycles of each second.
module traffic_sec_prescaler #(
    parameter int CLK_PER_SEC   = 50000000,
    parameter int SEC_CNT_WIDTH = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic second_cnt_pre_last,
    output logic sec_tick
);

    localparam logic [SEC_CNT_WIDTH-1:0] SEC_LAST     = SEC_CNT_WIDTH'(CLK_PER_SEC - 1);
    localparam logic [SEC_CNT_WIDTH-1:0] SEC_PRE_LAST = SEC_CNT_WIDTH'(CLK_PER_SEC - 2);

    logic [SEC_CNT_WIDTH-1:0] sec_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt <= '0;
        end else if (!en) begin
            sec_cnt <= '0;
        end else if (sec_cnt == SEC_LAST) begin
            sec_cnt <= '0;
        end else begin
            sec_cnt <= sec_cnt + SEC_CNT_WIDTH'(1);
        end
    end

    assign second_cnt_pre_last = en && (sec_cnt == SEC_PRE_LAST);
    assign sec_tick            = en && (sec_cnt == SEC_LAST);

endmodule

// File: rtl/traffic_timer_ctrl.sv
// Timing controller for the traffic light FSM: per-light countdown fed by the
// one-second prescaler, with run-time configurable shadow durations.
module traffic_timer_ctrl
    import traffic_pkg::*;
#(
    parameter int CLK_PER_SEC       = 50000000,
    parameter int SEC_CNT_WIDTH     = 26,
    parameter int LIGHT_CNT_WIDTH   = 7,
    parameter int LIGHT_STATE_WIDTH = traffic_pkg::LIGHT_STATE_WIDTH,
    parameter int GREEN_DEFAULT     = 30,
    parameter int YELLOW_DEFAULT    = 3,
    parameter int RED_DEFAULT       = 20
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [LIGHT_STATE_WIDTH-1:0] light_cnt_init,
    input  logic                         cfg_load,
    input  logic [LIGHT_CNT_WIDTH-1:0]   green_time,
    input  logic [LIGHT_CNT_WIDTH-1:0]   yellow_time,
    input  logic [LIGHT_CNT_WIDTH-1:0]   red_time,
    output logic                         second_cnt_pre_last,
    output logic                         light_cnt_last,
    output logic                         sec_tick,
    output logic [LIGHT_CNT_WIDTH-1:0]   remain_sec
);

    localparam logic [LIGHT_CNT_WIDTH-1:0] ONE        = LIGHT_CNT_WIDTH'(1);
    localparam logic [LIGHT_CNT_WIDTH-1:0] GREEN_RST  = LIGHT_CNT_WIDTH'(clamp_duration(32'(GREEN_DEFAULT)));
    localparam logic [LIGHT_CNT_WIDTH-1:0] YELLOW_RST = LIGHT_CNT_WIDTH'(clamp_duration(32'(YELLOW_DEFAULT)));
    localparam logic [LIGHT_CNT_WIDTH-1:0] RED_RST    = LIGHT_CNT_WIDTH'(clamp_duration(32'(RED_DEFAULT)));

    logic [LIGHT_CNT_WIDTH-1:0] shadow_green;
    logic [LIGHT_CNT_WIDTH-1:0] shadow_yellow;
    logic [LIGHT_CNT_WIDTH-1:0] shadow_red;
    logic [LIGHT_CNT_WIDTH-1:0] light_cnt;
    logic [LIGHT_CNT_WIDTH-1:0] light_cnt_next;

    traffic_sec_prescaler #(
        .CLK_PER_SEC   (CLK_PER_SEC),
        .SEC_CNT_WIDTH (SEC_CNT_WIDTH)
    ) u_prescaler (
        .clk                 (clk),
        .rst_n               (rst_n),
        .en                  (en),
        .second_cnt_pre_last (second_cnt_pre_last),
        .sec_tick            (sec_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_green  <= GREEN_RST;
            shadow_yellow <= YELLOW_RST;
            shadow_red    <= RED_RST;
        end else if (cfg_load) begin
            shadow_green  <= LIGHT_CNT_WIDTH'(clamp_duration(32'(green_time)));
            shadow_yellow <= LIGHT_CNT_WIDTH'(clamp_duration(32'(yellow_time)));
            shadow_red    <= LIGHT_CNT_WIDTH'(clamp_duration(32'(red_time)));
        end
    end

    // Disabled keeps green pre-armed because IDLE->GREEN has no init pulse.
    // Loads read the shadow before a same-edge cfg_load updates it.
    always_comb begin
        light_cnt_next = light_cnt;
        if (!en) begin
            light_cnt_next = shadow_green - ONE;
        end else if (light_cnt_init[RED_IDX]) begin
            light_cnt_next = shadow_red - ONE;
        end else if (light_cnt_init[YELLOW_IDX]) begin
            light_cnt_next = shadow_yellow - ONE;
        end else if (light_cnt_init[GREEN_IDX]) begin
            light_cnt_next = shadow_green - ONE;
        end else if (second_cnt_pre_last && (light_cnt != '0)) begin
            light_cnt_next = light_cnt - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            light_cnt <= GREEN_RST - ONE;
        end else begin
            light_cnt <= light_cnt_next;
        end
    end

    assign light_cnt_last = (light_cnt == '0);
    assign remain_sec     = light_cnt + ONE;

endmodule

// File: tb/tb_traffic_timer_ctrl.sv
// Bench for traffic_timer_ctrl: vector table, FSM-paired phase scenarios and
// randomized traffic checked against a duration/elapsed-event model.
module tb_traffic_timer_ctrl;

    localparam int C = 4;
    localparam int W = 7;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [2:0]   light_cnt_init;
    logic         cfg_load;
    logic [W-1:0] green_time;
    logic [W-1:0] yellow_time;
    logic [W-1:0] red_time;
    logic         second_cnt_pre_last;
    logic         light_cnt_last;
    logic         sec_tick;
    logic [W-1:0] remain_sec;

    int checks = 0;
    int errors = 0;

    // Reference model: loaded duration, pre_last events seen since the load,
    // and enabled edges since the last disable (which fixes the second phase).
    int m_en_cyc;
    int m_dur;
    int m_events;
    int m_sh[3];
    int ph_cnt;
    int fsm;
    logic [W-1:0] cur_g, cur_y, cur_r;
    logic [31:0]  exp_q[$];

    typedef struct packed {
        logic       en;
        logic [2:0] init;
        logic       cfg;
        logic [6:0] g;
        logic [6:0] y;
        logic [6:0] r;
        logic [6:0] remain;
        logic       last;
        logic       pre;
        logic       tick;
    } vec_t;

    vec_t tbl[18];

    always #5 clk = ~clk;

    traffic_timer_ctrl #(
        .CLK_PER_SEC       (C),
        .SEC_CNT_WIDTH     (3),
        .LIGHT_CNT_WIDTH   (W),
        .LIGHT_STATE_WIDTH (3),
        .GREEN_DEFAULT     (5),
        .YELLOW_DEFAULT    (2),
        .RED_DEFAULT       (3)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .en                  (en),
        .light_cnt_init      (light_cnt_init),
        .cfg_load            (cfg_load),
        .green_time          (green_time),
        .yellow_time         (yellow_time),
        .red_time            (red_time),
        .second_cnt_pre_last (second_cnt_pre_last),
        .light_cnt_last      (light_cnt_last),
        .sec_tick            (sec_tick),
        .remain_sec          (remain_sec)
    );

    function automatic int clamp(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic logic [31:0] dut_outs();
        return 32'({remain_sec, light_cnt_last, second_cnt_pre_last, sec_tick});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (remain/last/pre/tick packed where applicable)",
                     name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_en_cyc = 0;
        m_sh     = '{5, 2, 3};
        m_dur    = 5;
        m_events = 0;
        ph_cnt   = 0;
        fsm      = 0;
    endtask

    task automatic cycle(input logic en_i, input logic [2:0] init_i, input logic cfg_i,
                         input logic [W-1:0] g, input logic [W-1:0] y, input logic [W-1:0] r,
                         input bit chk);
        bit         pre_now;
        int         sec;
        logic [9:0] exp_v;
        en             = en_i;
        light_cnt_init = init_i;
        cfg_load       = cfg_i;
        green_time     = g;
        yellow_time    = y;
        red_time       = r;
        pre_now = en_i && ((m_en_cyc % C) == C - 2);
        @(posedge clk);
        if (!en_i) begin
            m_en_cyc = 0;
            m_dur    = m_sh[0];
            m_events = 0;
            ph_cnt   = 0;
        end else begin
            m_en_cyc++;
            ph_cnt++;
            if (init_i != 3'b000) begin
                m_dur    = init_i[2] ? m_sh[2] : (init_i[1] ? m_sh[1] : m_sh[0]);
                m_events = 0;
                if (exp_q.size() > 0) check("phase_len", ph_cnt, exp_q.pop_front());
                ph_cnt = 0;
            end else if (pre_now && (m_events < m_dur - 1)) begin
                m_events++;
            end
        end
        if (cfg_i) begin
            m_sh[0] = clamp(int'(g));
            m_sh[1] = clamp(int'(y));
            m_sh[2] = clamp(int'(r));
        end
        #1;
        if (chk) begin
            sec   = m_en_cyc % C;
            exp_v = {W'(m_dur - m_events), (m_events == m_dur - 1),
                     (en_i && sec == C - 2), (en_i && sec == C - 1)};
            check("model_out", dut_outs(), 32'(exp_v));
        end
    endtask

    // Paired FSM: hands over on light_cnt_last & pre_last; ovr forces an init vector.
    task automatic fsm_cycle(input logic en_i, input logic cfg_i, input logic [2:0] ovr);
        logic [2:0] init_v;
        int         nxt;
        init_v = 3'b000;
        nxt    = fsm;
        if (!en_i) begin
            nxt = 0;
        end else begin
            case (fsm)
                0: nxt = 1;
                1: if (light_cnt_last && second_cnt_pre_last) begin init_v = 3'b010; nxt = 2; end
                2: if (light_cnt_last && second_cnt_pre_last) begin init_v = 3'b100; nxt = 3; end
                default: if (light_cnt_last && second_cnt_pre_last) begin init_v = 3'b001; nxt = 1; end
            endcase
        end
        if (ovr != 3'b000) init_v = ovr;
        cycle(en_i, init_v, cfg_i, cur_g, cur_y, cur_r, 1'b1);
        fsm = nxt;
    endtask

    task automatic run_until_empty(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            fsm_cycle(1'b1, 1'b0, 3'b000);
            n++;
        end
        check("phases_done", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_to(input int target, input int budget);
        int n;
        n = 0;
        while (fsm != target && n < budget) begin
            fsm_cycle(1'b1, 1'b0, 3'b000);
            n++;
        end
        check("reach_state", fsm, target);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        en             = 1'b0;
        light_cnt_init = 3'b000;
        cfg_load       = 1'b0;
        cur_g          = 7'd5;
        cur_y          = 7'd2;
        cur_r          = 7'd3;
        green_time     = cur_g;
        yellow_time    = cur_y;
        red_time       = cur_r;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", dut_outs(), 32'({7'd5, 1'b0, 1'b0, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        // en, init, cfg, g, y, r | remain, last, pre, tick
        tbl[0]  = '{1'b0, 3'b000, 1'b0, 7'd5, 7'd2, 7'd3, 7'd5, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 3'b000, 1'b0, 7'd5, 7'd2, 7'd3, 7'd5, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 3'b000, 1'b0, 7'd5, 7'd2, 7'd3, 7'd5, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 3'b000, 1'b0, 7'd5, 7'd2, 7'd3, 7'd4, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 3'b110, 1'b0, 7'd5, 7'd2, 7'd3, 7'd3, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 3'b011, 1'b0, 7'd5, 7'd2, 7'd3, 7'd2, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 3'b000, 1'b0, 7'd5, 7'd2, 7'd3, 7'd2, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 3'b000, 1'b0, 7'd5, 7'd2, 7'd3, 7'd1, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 3'b000, 1'b0, 7'd5, 7'd2, 7'd3, 7'd1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 3'b000, 1'b0, 7'd5, 7'd2, 7'd3, 7'd1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 3'b000, 1'b0, 7'd5, 7'd2, 7'd3, 7'd1, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 3'b000, 1'b0, 7'd5, 7'd2, 7'd3, 7'd1, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 3'b000, 1'b1, 7'd0, 7'd7, 7'd0, 7'd1, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 3'b001, 1'b0, 7'd0, 7'd7, 7'd0, 7'd1, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 3'b100, 1'b1, 7'd5, 7'd2, 7'd6, 7'd1, 1'b1, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 3'b100, 1'b0, 7'd5, 7'd2, 7'd6, 7'd6, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 3'b000, 1'b0, 7'd5, 7'd2, 7'd6, 7'd5, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 3'b100, 1'b0, 7'd5, 7'd2, 7'd6, 7'd5, 1'b0, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].en, tbl[i].init, tbl[i].cfg, tbl[i].g, tbl[i].y, tbl[i].r, 1'b0);
            check($sformatf("vec%0d", i), dut_outs(),
                  32'({tbl[i].remain, tbl[i].last, tbl[i].pre, tbl[i].tick}));
        end

        // Free run: first green 19, yellow 8, red 12, then a full 20-cycle green.
        do_reset();
        exp_q.push_back(19);
        exp_q.push_back(8);
        exp_q.push_back(12);
        exp_q.push_back(20);
        run_until_empty(200);
        exp_q.push_back(8);
        run_until_empty(100);

        // Reconfigure during red: red unaffected, green 2 s, yellow clamped to 1 s.
        cur_g = 7'd2;
        fsm_cycle(1'b1, 1'b1, 3'b000);
        cur_y = 7'd0;
        fsm_cycle(1'b1, 1'b1, 3'b000);
        exp_q.push_back(12);
        exp_q.push_back(8);
        exp_q.push_back(4);
        run_until_empty(200);

        // One-cycle enable drop mid-yellow restarts at a fresh green.
        do_reset();
        exp_q.push_back(19);
        run_until_empty(100);
        fsm_cycle(1'b1, 1'b0, 3'b000);
        fsm_cycle(1'b1, 1'b0, 3'b000);
        fsm_cycle(1'b0, 1'b0, 3'b000);
        check("en_drop_outs", dut_outs(), 32'({7'd5, 1'b0, 1'b0, 1'b0}));
        exp_q.push_back(19);
        run_until_empty(100);

        // Asynchronous reset between edges in the middle of red.
        run_to(3, 100);
        fsm_cycle(1'b1, 1'b0, 3'b000);
        fsm_cycle(1'b1, 1'b0, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", dut_outs(), 32'({7'd5, 1'b0, 1'b0, 1'b0}));
        #1;
        rst_n = 1'b1;
        model_reset();
        exp_q.push_back(19);
        run_until_empty(100);

        // Randomized traffic with occasional reconfig, enable drops and stray init vectors.
        for (int i = 0; i < 1500; i++) begin
            logic       en_r;
            logic       cfg_r;
            logic [2:0] ovr;
            en_r  = ($urandom_range(0, 49) != 0);
            cfg_r = ($urandom_range(0, 29) == 0);
            if (cfg_r) begin
                cur_g = W'($urandom_range(0, 6));
                cur_y = W'($urandom_range(0, 6));
                cur_r = W'($urandom_range(0, 6));
            end
            ovr = ($urandom_range(0, 49) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            fsm_cycle(en_r, cfg_r, ovr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
